// File: rtl/ula_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus a WIDTH-cycle
// unsigned shift-add multiplier, with preset, clock enable and async clear.
module ula_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             CLR_n,
  input  logic             PR,
  input  logic             EN,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OPCODE,
  output logic [WIDTH:0]   s,
  output logic             z,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, MUL} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH:0]       alu_res;
  logic [WIDTH:0]       mul_res;
  logic                 last_iter;
  logic                 accept_mul;

  function automatic logic [WIDTH:0] alu(input logic [2:0] op,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
    case (op)
      3'b000:  alu = {1'b0, a};
      3'b001:  alu = {1'b0, a} + {1'b0, b};
      3'b010:  alu = {1'b0, a} - {1'b0, b};
      3'b011:  alu = {1'b0, a & b};
      3'b100:  alu = {1'b0, a | b};
      3'b110:  alu = {1'b0, ~a};
      3'b111:  alu = {1'b0, ~b};
      default: alu = '0;
    endcase
  endfunction

  // Low half of the product, with bit WIDTH flagging a nonzero high half.
  function automatic logic [WIDTH:0] mul_pack(input logic [2*WIDTH-1:0] p);
    mul_pack = {|p[2*WIDTH-1:WIDTH], p[WIDTH-1:0]};
  endfunction

  assign acc_nxt    = acc + (mplier[0] ? mcand : '0);
  assign alu_res    = alu(OPCODE, A, B);
  assign mul_res    = mul_pack(acc_nxt);
  assign last_iter  = (cnt == CW'(WIDTH - 1));
  assign accept_mul = EN && !PR && start && (state == IDLE) && (OPCODE == 3'b101);

  // Multiplier datapath: operands only matter while in MUL, so no reset.
  always_ff @(posedge clk) begin
    if (accept_mul) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, A};
      mplier <= B;
    end else if (EN && !PR && (state == MUL)) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      state <= IDLE;
      cnt   <= '0;
      s     <= '0;
      z     <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (PR) begin
      state <= IDLE;
      cnt   <= '0;
      s     <= '1;
      z     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (!EN) begin
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (OPCODE == 3'b101) begin
              state <= MUL;
              busy  <= 1'b1;
              cnt   <= '0;
            end else begin
              s    <= alu_res;
              z    <= (alu_res == '0);
              done <= 1'b1;
            end
          end
        end
        MUL: begin
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            state <= IDLE;
            cnt   <= '0;
            s     <= mul_res;
            z     <= (mul_res == '0);
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Bench for ula_seq (WIDTH=8): directed literal cases plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_ula_seq;

  logic       clk;
  logic       CLR_n;
  logic       PR;
  logic       EN;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] OPCODE;
  logic [8:0] s;
  logic       z;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  ula_seq #(.WIDTH(8)) dut (
    .clk(clk), .CLR_n(CLR_n), .PR(PR), .EN(EN), .start(start),
    .A(A), .B(B), .OPCODE(OPCODE), .s(s), .z(z), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: an op either completes at once or, for MUL, after a
  // countdown of 8 enabled cycles with the product taken from A*B.
  logic [8:0]  m_s    = 9'h000;
  logic        m_z    = 1'b1;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_rem  = 0;
  logic [15:0] m_prod = 16'h0;

  function automatic logic [8:0] ref_op(input logic [2:0] opc,
                                        input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    case (opc)
      3'd0: return {1'b0, a};
      3'd1: return 9'(a) + 9'(b);
      3'd2: return 9'(a) - 9'(b);
      3'd3: return {1'b0, a & b};
      3'd4: return {1'b0, a | b};
      3'd5: begin
        p = 16'(a) * 16'(b);
        return {p[15:8] != 8'h00, p[7:0]};
      end
      3'd6: return {1'b0, ~a};
      default: return {1'b0, ~b};
    endcase
  endfunction

  always @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      m_s = 9'h000; m_z = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
    end else if (PR) begin
      m_s = 9'h1FF; m_z = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
    end else if (!EN) begin
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_busy = 1'b0;
          m_s    = {m_prod[15:8] != 8'h00, m_prod[7:0]};
          m_z    = (m_s == 9'h000);
          m_done = 1'b1;
        end
      end else if (start) begin
        if (OPCODE == 3'd5) begin
          m_busy = 1'b1;
          m_rem  = 8;
          m_prod = 16'(A) * 16'(B);
        end else begin
          m_s    = ref_op(OPCODE, A, B);
          m_z    = (m_s == 9'h000);
          m_done = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always begin
    @(posedge clk);
    #2;
    chk("cyc_s", 32'(s), 32'(m_s));
    chk("cyc_z", 32'(z), 32'(m_z));
    chk("cyc_busy", 32'(busy), 32'(m_busy));
    chk("cyc_done", 32'(done), 32'(m_done));
  end

  task automatic op(input logic [2:0] opc, input logic [7:0] a, input logic [7:0] b);
    OPCODE = opc; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_mul(input bit freeze, output int nb);
    int guard;
    nb = 0;
    guard = 0;
    while (!done && guard < 60) begin
      if (busy) nb++;
      A = 8'($urandom);
      B = 8'($urandom);
      start = 1'($urandom_range(0, 1));
      if (freeze && nb == 3) EN = 1'b0;
      if (freeze && nb == 8) EN = 1'b1;
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    EN = 1'b1;
    if (guard >= 60) chk("mul_timeout", 32'(guard), 32'd0);
  endtask

  int nb;

  initial begin
    CLR_n = 1'b0; PR = 1'b0; EN = 1'b1; start = 1'b0;
    A = 8'h00; B = 8'h00; OPCODE = 3'd0;
    @(negedge clk);
    chk("rst_s", 32'(s), 32'h000);
    chk("rst_z", 32'(z), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    CLR_n = 1'b1;

    op(3'd1, 8'h04, 8'h03);
    chk("add_s", 32'(s), 32'h007);
    chk("add_z", 32'(z), 32'h0);
    chk("add_done", 32'(done), 32'h1);
    chk("add_busy", 32'(busy), 32'h0);
    @(negedge clk);
    chk("add_done_once", 32'(done), 32'h0);

    op(3'd2, 8'h02, 8'h08); chk("sub_borrow", 32'(s), 32'h1FA);
    op(3'd2, 8'h08, 8'h02); chk("sub_pos", 32'(s), 32'h006);
    op(3'd2, 8'h05, 8'h05); chk("sub_zero", 32'(s), 32'h000);
    chk("sub_zero_z", 32'(z), 32'h1);
    op(3'd3, 8'hAA, 8'hCC); chk("and", 32'(s), 32'h088);
    op(3'd4, 8'hAA, 8'hCC); chk("or", 32'(s), 32'h0EE);
    op(3'd6, 8'hAA, 8'hCC); chk("nota", 32'(s), 32'h055);
    op(3'd7, 8'hAA, 8'hCC); chk("notb", 32'(s), 32'h033);

    op(3'd5, 8'd13, 8'd11);
    wait_mul(1'b0, nb);
    chk("mul1_busy_cycles", 32'(nb), 32'd8);
    chk("mul1_s", 32'(s), 32'h08F);
    chk("mul1_done", 32'(done), 32'h1);
    @(negedge clk);
    chk("mul1_done_once", 32'(done), 32'h0);

    op(3'd5, 8'd200, 8'd3);
    wait_mul(1'b0, nb);
    chk("mul2_s", 32'(s), 32'h158);
    op(3'd1, 8'h01, 8'h01);
    chk("b2b_accept", 32'(s), 32'h002);

    op(3'd5, 8'd13, 8'd11);
    repeat (3) @(negedge clk);
    #2 CLR_n = 1'b0;
    #1;
    chk("clr_s", 32'(s), 32'h000);
    chk("clr_z", 32'(z), 32'h1);
    chk("clr_busy", 32'(busy), 32'h0);
    chk("clr_done", 32'(done), 32'h0);
    @(negedge clk);
    CLR_n = 1'b1;
    repeat (10) @(negedge clk);

    op(3'd5, 8'd13, 8'd11);
    repeat (2) @(negedge clk);
    PR = 1'b1;
    @(negedge clk);
    PR = 1'b0;
    chk("pr_s", 32'(s), 32'h1FF);
    chk("pr_z", 32'(z), 32'h0);
    chk("pr_busy", 32'(busy), 32'h0);
    chk("pr_done", 32'(done), 32'h0);
    repeat (10) @(negedge clk);

    op(3'd5, 8'd13, 8'd11);
    wait_mul(1'b1, nb);
    chk("freeze_busy_cycles", 32'(nb), 32'd13);
    chk("freeze_s", 32'(s), 32'h08F);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!CLR_n) CLR_n = 1'b1;
      else if ($urandom_range(0, 99) == 0) CLR_n = 1'b0;
      PR     = ($urandom_range(0, 29) == 0);
      EN     = ($urandom_range(0, 7) != 0);
      start  = ($urandom_range(0, 2) == 0);
      OPCODE = 3'($urandom_range(0, 7));
      A      = 8'($urandom);
      B      = 8'($urandom);
    end
    @(negedge clk);
    CLR_n = 1'b1; PR = 1'b0; EN = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
